// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8:1 mux round-robin arbiter.
// Holds the FSM state encoding, the mux geometry and the one-hot helper.
package mux_arb_pkg;

    localparam int N    = 8;
    localparam int SELW = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [N-1:0] onehot(input logic [SELW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first unmasked request at or after ptr.
// Scanning wraps modulo N through natural SELW-bit overflow.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic [N-1:0]    mask,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [N-1:0] cand;

    assign cand = req & ~mask;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Walk from farthest to nearest so the candidate closest to ptr wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[ptr + SELW'(i)]) begin
                found = 1'b1;
                idx   = ptr + SELW'(i);
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of the 8:1 mux; one owner at a time,
// released on done, withdrawal, hold timeout or disable.
//
//   state    | meaning
//   ST_IDLE  | no owner, gnt=0, searching from ptr
//   ST_GRANT | requester sel owns the mux, cnt counts held cycles
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [SELW-1:0] sel,
    output logic [N-1:0]    gnt,
    output logic            valid
);

    localparam int              CNTW     = 8;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD_MAX - 1);

    state_t          state, state_nx;
    logic [SELW-1:0] sel_nx;
    logic [N-1:0]    gnt_nx;
    logic [SELW-1:0] ptr, ptr_nx;
    logic [CNTW-1:0] cnt, cnt_nx;

    logic [SELW-1:0] pick_ptr;
    logic [N-1:0]    pick_mask;
    logic            found;
    logic [SELW-1:0] idx;
    logic            rel;

    // While granted, the search always prepares the hand-over: start after the
    // owner and exclude it, so a lone requester falls back through IDLE.
    assign pick_ptr  = (state == ST_GRANT) ? sel + SELW'(1) : ptr;
    assign pick_mask = (state == ST_GRANT) ? onehot(sel) : '0;

    rr_pick u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .found (found),
        .idx   (idx)
    );

    assign rel   = done | ~req[sel] | (cnt == CNT_LAST) | ~en;
    assign valid = |gnt;

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        gnt_nx   = gnt;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (en && found) begin
                    state_nx = ST_GRANT;
                    sel_nx   = idx;
                    gnt_nx   = onehot(idx);
                    cnt_nx   = '0;
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    ptr_nx = sel + SELW'(1);
                    cnt_nx = '0;
                    if (en && found) begin
                        sel_nx = idx;
                        gnt_nx = onehot(idx);
                    end else begin
                        state_nx = ST_IDLE;
                        gnt_nx   = '0;
                    end
                end else if (cnt != '1) begin
                    cnt_nx = cnt + CNTW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sel   <= '0;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            gnt   <= gnt_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with hand-computed expectations;
// grant invariants are rechecked after every clock.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       valid;

    int n_checks = 0;
    int n_pass   = 0;

    mux8_rr_arbiter #(.HOLD_MAX(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .req   (req),
        .done  (done),
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("onehot", 32'(gnt & (gnt - 8'd1)), 32'd0);
        chk("valid_or", 32'(valid), 32'(|gnt));
        if (valid) chk("gnt_sel", 32'(gnt), 32'(8'd1 << sel));
    endtask

    task automatic expect_grant(input string tag, input int s);
        chk({tag, "_sel"}, 32'(sel), 32'(s));
        chk({tag, "_gnt"}, 32'(gnt), 32'(8'd1 << s));
        chk({tag, "_valid"}, 32'(valid), 32'd1);
    endtask

    task automatic expect_idle(input string tag, input int s);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_sel"}, 32'(sel), 32'(s));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_idle("rst", 0);
        rst_n = 1'b1;

        // 1: async reset while requester 5 owns the mux
        en  = 1'b1;
        req = 8'h20;
        tick();
        expect_grant("pre_rst", 5);
        #2;
        rst_n = 1'b0;
        req   = 8'h00;
        #1;
        expect_idle("async_rst", 0);
        #1;
        rst_n = 1'b1;
        tick();
        expect_idle("post_rst", 0);
        tick();
        expect_idle("post_rst2", 0);

        // 2: single requester, done, regrant through IDLE
        req = 8'h08;
        tick();
        expect_grant("single", 3);
        done = 1'b1;
        tick();
        expect_idle("single_done", 3);
        done = 1'b0;
        tick();
        expect_grant("single_regrant", 3);
        req = 8'h88;                       // new non-owner request must not disturb owner 3
        tick();
        expect_grant("nonowner", 3);
        done = 1'b1;
        tick();
        expect_grant("switch7", 7);        // ptr=4 after release, scan finds 7
        done = 1'b0;
        req  = 8'h00;
        tick();
        expect_idle("withdraw7", 7);

        // 3: fairness with all requesting, done on 2nd cycle of each grant
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req   = 8'hFF;
        en    = 1'b1;
        tick();
        expect_grant("rr_first", 0);
        for (int i = 0; i < 8; i++) begin
            done = 1'b0;
            tick();
            chk("rr_hold", 32'(sel), 32'(i));
            done = 1'b1;
            tick();
            expect_grant("rr_next", (i + 1) % 8);
        end
        done = 1'b0;

        // 4: pointer wrap; owner 0 withdraws toward 6, then 6 releases and scan wraps to 0
        req = 8'h40;
        tick();
        expect_grant("wrap_6", 6);
        req  = 8'h41;
        done = 1'b1;
        tick();
        expect_grant("wrap_0", 0);
        tick();
        expect_grant("wrap_back6", 6);
        done = 1'b0;

        // 5: timeout, owner held exactly 15 cycles then hand-over without bubble
        req = 8'h03;
        tick();
        expect_grant("to_start", 0);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("to_hold0", 32'(sel), 32'd0);
        end
        tick();
        expect_grant("to_switch1", 1);
        for (int i = 1; i < 15; i++) begin
            tick();
            chk("to_hold1", 32'(sel), 32'd1);
        end
        tick();
        expect_grant("to_switch0", 0);

        // 6: withdraw and disable
        req = 8'h04;
        tick();
        expect_grant("wd_2", 2);
        req = 8'h00;
        tick();
        expect_idle("wd_rel", 2);
        req = 8'hFF;
        tick();
        expect_grant("wd_3", 3);
        en = 1'b0;
        tick();
        expect_idle("dis", 3);
        tick();
        expect_idle("dis_hold", 3);
        // disabling released owner 3, so the pointer sits at 4
        en = 1'b1;
        tick();
        expect_grant("resume", 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
